// File: rtl/branch_predictor_pkg.sv
// Shared pipeline constants for the branch predictor: counter encodings,
// default table depth and PC bit positions for index/tag extraction.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int unsigned DEF_ENTRIES = 16;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned IDX_LSB     = 2;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating predictor counter: steps toward ST on taken,
// toward SNT on not-taken, and holds at either end.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t state,
    input  logic taken,
    output ctr_t next_state
);

    always_comb begin
        next_state = state;
        unique case (state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// zero-latency lookup from registered state and saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  PC_F,
    output logic             Br_Dectected,
    output logic             Br_PredictedBit,
    output logic [PC_W-1:0]  Pred_Target,
    input  logic             Br_Dectected_Ex,
    input  logic [PC_W-1:0]  PC_Ex,
    input  logic             Br_Taken_Ex,
    input  logic [PC_W-1:0]  Target_Ex,
    input  logic             Pred_Taken_Ex,
    output logic             Mispredict,
    output logic [CNT_W-1:0] Br_Count,
    output logic [CNT_W-1:0] Miss_Count
);

    localparam int unsigned IDX     = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB = IDX_LSB + IDX;
    localparam int unsigned TAG_W   = PC_W - TAG_LSB;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    ctr_t             ctr_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];

    logic [IDX-1:0]   f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    ctr_t             e_next;

    assign f_idx = PC_F[IDX_LSB +: IDX];
    assign f_tag = PC_F[PC_W-1:TAG_LSB];
    assign e_idx = PC_Ex[IDX_LSB +: IDX];
    assign e_tag = PC_Ex[PC_W-1:TAG_LSB];

    // Lookup reads only registered contents, so a same-cycle update is not visible yet
    always_comb begin
        f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        Br_Dectected    = f_hit;
        Br_PredictedBit = f_hit & ctr_q[f_idx][1];
        Pred_Target     = f_hit ? tgt_q[f_idx] : '0;
    end

    assign e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign Mispredict = Br_Dectected_Ex & (Br_Taken_Ex ^ Pred_Taken_Ex);

    sat_counter2 u_sat (
        .state      (ctr_q[e_idx]),
        .taken      (Br_Taken_Ex),
        .next_state (e_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= WNT;
                tgt_q[i]   <= '0;
            end
        end else if (Br_Dectected_Ex) begin
            valid_q[e_idx] <= 1'b1;
            tag_q[e_idx]   <= e_tag;
            if (e_hit) begin
                ctr_q[e_idx] <= e_next;
            end else begin
                ctr_q[e_idx] <= Br_Taken_Ex ? WT : WNT;
            end
            // A miss always installs the target; a hit refreshes it only when taken
            if (!e_hit || Br_Taken_Ex) begin
                tgt_q[e_idx] <= Target_Ex;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Br_Count   <= '0;
            Miss_Count <= '0;
        end else if (Br_Dectected_Ex) begin
            if (Br_Count != '1) begin
                Br_Count <= Br_Count + 1'b1;
            end
            if (Mispredict && (Miss_Count != '1)) begin
                Miss_Count <= Miss_Count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against a table-level behavioural model.
module tb_branch_predictor;

    localparam int unsigned N    = 16;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = 15;

    logic          clk, rst;
    logic [31:0]   PC_F, PC_Ex, Target_Ex, Pred_Target;
    logic          Br_Dectected, Br_PredictedBit;
    logic          Br_Dectected_Ex, Br_Taken_Ex, Pred_Taken_Ex, Mispredict;
    logic [CW-1:0] Br_Count, Miss_Count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(N), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_F            (PC_F),
        .Br_Dectected    (Br_Dectected),
        .Br_PredictedBit (Br_PredictedBit),
        .Pred_Target     (Pred_Target),
        .Br_Dectected_Ex (Br_Dectected_Ex),
        .PC_Ex           (PC_Ex),
        .Br_Taken_Ex     (Br_Taken_Ex),
        .Target_Ex       (Target_Ex),
        .Pred_Taken_Ex   (Pred_Taken_Ex),
        .Mispredict      (Mispredict),
        .Br_Count        (Br_Count),
        .Miss_Count      (Miss_Count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one record per table slot, counters as plain integers 0..3
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    int          m_ctr   [N];
    logic [31:0] m_tgt   [N];
    int unsigned m_br, m_miss;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % N;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> 6;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'h0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
        end
        m_br = 0; m_miss = 0;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic tk,
                                     input logic [31:0] tg, input logic pr);
        int unsigned i = idx_of(pc);
        if (m_br < CMAX) m_br++;
        if ((tk != pr) && (m_miss < CMAX)) m_miss++;
        if (m_hit(pc)) begin
            if (tk) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_tgt[i] = tg;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else begin
            m_valid[i] = 1; m_tag[i] = tag_of(pc); m_ctr[i] = tk ? 2 : 1; m_tgt[i] = tg;
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic drive(input logic [31:0] pcf, input logic ex, input logic [31:0] pce,
                         input logic tk, input logic [31:0] tg, input logic pr);
        PC_F = pcf; Br_Dectected_Ex = ex; PC_Ex = pce;
        Br_Taken_Ex = tk; Target_Ex = tg; Pred_Taken_Ex = pr;
        #1;
    endtask

    task automatic tick();
        logic        ex = Br_Dectected_Ex, tk = Br_Taken_Ex, pr = Pred_Taken_Ex;
        logic [31:0] pce = PC_Ex, tg = Target_Ex;
        @(posedge clk);
        if (rst) m_reset();
        else if (ex) m_update(pce, tk, tg, pr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_Dectected !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", Br_Dectected); end
        checks++; if (Br_PredictedBit !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", Br_PredictedBit); end
        checks++; if (Pred_Target !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", Pred_Target); end
        checks++; if (Br_Count !== 4'h0) begin errors++; $display("FAIL reset_br_count got %h exp 0", Br_Count); end
        checks++; if (Miss_Count !== 4'h0) begin errors++; $display("FAIL reset_miss_count got %h exp 0", Miss_Count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alloc();
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        checks++; if (Mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %b exp 1", Mispredict); end
        checks++; if (Br_Dectected !== 1'b0) begin errors++; $display("FAIL alloc_pre_hit got %b exp 0", Br_Dectected); end
        tick();
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_Dectected !== 1'b1) begin errors++; $display("FAIL alloc_hit got %b exp 1", Br_Dectected); end
        checks++; if (Br_PredictedBit !== 1'b1) begin errors++; $display("FAIL alloc_pred got %b exp 1", Br_PredictedBit); end
        checks++; if (Pred_Target !== 32'h100) begin errors++; $display("FAIL alloc_target got %h exp 100", Pred_Target); end
        checks++; if (Br_Count !== 4'd1) begin errors++; $display("FAIL alloc_br_count got %0d exp 1", Br_Count); end
        checks++; if (Miss_Count !== 4'd1) begin errors++; $display("FAIL alloc_miss_count got %0d exp 1", Miss_Count); end
    endtask

    task automatic test_walk();
        bit exp_pred [6] = '{1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            logic tk = (i < 3);
            logic pr = m_pred(32'h40);
            drive(32'h40, 1'b1, 32'h40, tk, tk ? 32'h100 : 32'hBAD0, pr);
            checks++; if (Mispredict !== (tk ^ pr)) begin errors++; $display("FAIL walk_mispredict step %0d got %b exp %b", i, Mispredict, tk ^ pr); end
            tick();
            drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checks++; if (Br_PredictedBit !== exp_pred[i]) begin errors++; $display("FAIL walk_pred step %0d got %b exp %b", i, Br_PredictedBit, exp_pred[i]); end
            checks++; if (Pred_Target !== 32'h100) begin errors++; $display("FAIL walk_target step %0d got %h exp 100", i, Pred_Target); end
        end
    endtask

    task automatic test_alias();
        drive(32'h40, 1'b1, 32'h80, 1'b0, 32'h200, 1'b0);
        tick();
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_Dectected !== 1'b1) begin errors++; $display("FAIL alias_new_hit got %b exp 1", Br_Dectected); end
        checks++; if (Br_PredictedBit !== 1'b0) begin errors++; $display("FAIL alias_new_pred got %b exp 0", Br_PredictedBit); end
        checks++; if (Pred_Target !== 32'h200) begin errors++; $display("FAIL alias_new_target got %h exp 200", Pred_Target); end
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_Dectected !== 1'b0) begin errors++; $display("FAIL alias_old_hit got %b exp 0", Br_Dectected); end
        checks++; if (Pred_Target !== 32'h0) begin errors++; $display("FAIL alias_old_target got %h exp 0", Pred_Target); end
        // One taken step from 01 must reach 10 (predict taken); from 00 it would not
        drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
        tick();
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_PredictedBit !== 1'b1) begin errors++; $display("FAIL alias_ctr01 got %b exp 1", Br_PredictedBit); end
        checks++; if (Pred_Target !== 32'h300) begin errors++; $display("FAIL alias_taken_target got %h exp 300", Pred_Target); end
    endtask

    task automatic test_same_cycle();
        drive(32'h80, 1'b1, 32'h80, 1'b0, 32'hDEAD, 1'b1);
        checks++; if (Br_PredictedBit !== 1'b1) begin errors++; $display("FAIL same_old_pred got %b exp 1", Br_PredictedBit); end
        checks++; if (Pred_Target !== 32'h300) begin errors++; $display("FAIL same_old_target got %h exp 300", Pred_Target); end
        checks++; if (Mispredict !== 1'b1) begin errors++; $display("FAIL same_mispredict got %b exp 1", Mispredict); end
        tick();
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_PredictedBit !== 1'b0) begin errors++; $display("FAIL same_new_pred got %b exp 0", Br_PredictedBit); end
        checks++; if (Pred_Target !== 32'h300) begin errors++; $display("FAIL same_nt_target got %h exp 300", Pred_Target); end
    endtask

    task automatic test_no_update();
        int unsigned br0 = m_br;
        for (int i = 0; i < 8; i++) begin
            drive(32'h80, 1'b0, 32'h80, 1'($urandom), $urandom, 1'($urandom));
            checks++; if (Mispredict !== 1'b0) begin errors++; $display("FAIL idle_mispredict got %b exp 0", Mispredict); end
            tick();
        end
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Pred_Target !== 32'h300 || Br_PredictedBit !== 1'b0) begin errors++; $display("FAIL idle_entry got %h/%b exp 300/0", Pred_Target, Br_PredictedBit); end
        checks++; if (Br_Count !== CW'(br0)) begin errors++; $display("FAIL idle_br_count got %0d exp %0d", Br_Count, br0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pcf = rand_pc();
            logic [31:0] pce = rand_pc();
            logic        ex  = ($urandom_range(0, 3) != 0);
            logic        tk  = 1'($urandom);
            logic        pr  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pred(pce);
            drive(pcf, ex, pce, tk, $urandom, pr);
            checks++; if (Br_Dectected !== m_hit(pcf)) begin errors++; $display("FAIL rnd_hit %0d pc %h got %b exp %b", i, pcf, Br_Dectected, m_hit(pcf)); end
            checks++; if (Br_PredictedBit !== m_pred(pcf)) begin errors++; $display("FAIL rnd_pred %0d pc %h got %b exp %b", i, pcf, Br_PredictedBit, m_pred(pcf)); end
            checks++; if (Pred_Target !== m_target(pcf)) begin errors++; $display("FAIL rnd_target %0d pc %h got %h exp %h", i, pcf, Pred_Target, m_target(pcf)); end
            checks++; if (Mispredict !== (ex && (tk != pr))) begin errors++; $display("FAIL rnd_mispredict %0d got %b exp %b", i, Mispredict, ex && (tk != pr)); end
            checks++; if (Br_Count !== CW'(m_br)) begin errors++; $display("FAIL rnd_br_count %0d got %0d exp %0d", i, Br_Count, m_br); end
            checks++; if (Miss_Count !== CW'(m_miss)) begin errors++; $display("FAIL rnd_miss_count %0d got %0d exp %0d", i, Miss_Count, m_miss); end
            tick();
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        #1;
        m_reset();
        checks++; if (Br_Count !== 4'h0) begin errors++; $display("FAIL sat_clear got %0d exp 0", Br_Count); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
            tick();
        end
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_Count !== 4'hF) begin errors++; $display("FAIL sat_br_count got %h exp F", Br_Count); end
        checks++; if (Miss_Count !== 4'hF) begin errors++; $display("FAIL sat_miss_count got %h exp F", Miss_Count); end
        checks++; if (Br_Dectected !== 1'b1) begin errors++; $display("FAIL sat_pre_rst_hit got %b exp 1", Br_Dectected); end
        // Reset lands mid-cycle with an update pending; it must act immediately
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0);
        rst = 1'b1;
        #1;
        m_reset();
        checks++; if (Br_Count !== 4'h0 || Miss_Count !== 4'h0) begin errors++; $display("FAIL async_rst_counts got %h/%h exp 0/0", Br_Count, Miss_Count); end
        checks++; if (Br_Dectected !== 1'b0) begin errors++; $display("FAIL async_rst_hit got %b exp 0", Br_Dectected); end
        tick();
        rst = 1'b0;
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (Br_Dectected !== 1'b0 || Pred_Target !== 32'h0) begin errors++; $display("FAIL rst_drop_update got %b/%h exp 0/0", Br_Dectected, Pred_Target); end
        checks++; if (Br_Count !== 4'h0) begin errors++; $display("FAIL rst_drop_count got %0d exp 0", Br_Count); end
    endtask

    initial begin
        rst = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        m_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_alloc();
        test_walk();
        test_alias();
        test_same_cycle();
        test_no_update();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, power of two: number of branch-table entries.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PC_F  input  32  fetch-stage PC used for lookup.
REQ-006 SHALL have port Br_Dectected  output  1  lookup hit: valid entry whose tag matches PC_F.
REQ-007 SHALL have port Br_PredictedBit  output  1  predicted taken; equals the MSB of the hit entry's counter, 0 on a miss.
REQ-008 SHALL have port Pred_Target  output  32  target stored in the hit entry, 0 on a miss.
REQ-009 SHALL have port Br_Dectected_Ex  input  1  a resolved conditional branch is in EX this cycle.
REQ-010 SHALL have port PC_Ex  input  32  PC of the EX branch.
REQ-011 SHALL have port Br_Taken_Ex  input  1  actual branch outcome.
REQ-012 SHALL have port Target_Ex  input  32  actual computed target.
REQ-013 SHALL have port Pred_Taken_Ex  input  1  prediction carried down the pipeline with this branch.
REQ-014 SHALL have port Mispredict  output  1  combinational: Br_Dectected_Ex and (Br_Taken_Ex != Pred_Taken_Ex).
REQ-015 SHALL have ports Br_Count and Miss_Count  output  CNT_W each  resolved-branch and mispredict counters.

Function
REQ-016 SHALL index the table with PC[2+IDX-1:2], IDX=log2(ENTRIES), and tag with PC[31:2+IDX].
REQ-017 SHALL give each entry: valid bit, tag, 2-bit saturating counter, 32-bit target.
REQ-018 SHALL perform lookup combinationally from registered table contents (zero-cycle latency).
REQ-019 SHALL, when Br_Dectected_Ex=1 and the EX entry hits, move the counter up on taken and down on not-taken, saturating at 11 and 00.
REQ-020 SHALL, on a taken update, overwrite the stored target with Target_Ex; on not-taken, leave the target unchanged.
REQ-021 SHALL, when Br_Dectected_Ex=1 and the entry misses (invalid or tag mismatch), allocate: valid=1, tag from PC_Ex, counter=10 if taken else 01, target=Target_Ex.
REQ-022 SHALL apply every update at the rising edge following the EX cycle; the updated entry is visible to lookup from the next cycle on.
REQ-023 SHALL, when lookup and update address the same entry in the same cycle, return the pre-update contents (read-before-write).
REQ-024 SHALL leave the table unchanged when Br_Dectected_Ex=0, regardless of other EX inputs.
REQ-025 SHALL increment Br_Count on every cycle with Br_Dectected_Ex=1, and Miss_Count additionally when Mispredict=1.
REQ-026 SHALL saturate both statistics counters at all-ones (no wrap-around).
REQ-027 SHALL keep Mispredict at 0 whenever Br_Dectected_Ex=0.

Reset
REQ-028 SHALL, while rst=1, clear all valid bits and set all counters to 01; tags and targets SHALL be cleared to 0.
REQ-029 SHALL, while rst=1, clear Br_Count and Miss_Count; Br_Dectected, Br_PredictedBit and Pred_Target SHALL read 0 as a result.
REQ-030 SHALL ignore an update pending at the same edge that rst asserts; reset mid-operation discards it.

Structure
REQ-031 SHALL take the counter encodings (SNT=00, WNT=01, WT=10, ST=11), the default ENTRIES value and the index/tag bit-position constants from the shared pipeline package.
REQ-032 SHALL implement the saturating 2-bit update in one sub-module, sat_counter2 (inputs: current state, taken; output: next state), instantiated by the update logic.

Verification
REQ-033 Reset, then PC_F=0x0000_0040 -> Br_Dectected=0, Br_PredictedBit=0, Pred_Target=0, Br_Count=0.
REQ-034 EX update PC_Ex=0x40, taken, Target_Ex=0x100, Pred_Taken_Ex=0 -> Mispredict=1 that cycle; next cycle lookup 0x40 gives hit, predicted=1, target 0x100; Br_Count=1, Miss_Count=1.
REQ-035 Three more taken updates on 0x40, then three not-taken -> counter walks 10,11,11,11,10,01,00; prediction flips to 0 after the second not-taken.
REQ-036 Aliasing: entry for 0x40 valid, update PC_Ex=0x80 (same index at ENTRIES=16) not-taken -> entry replaced with counter 01; lookup 0x40 misses.
REQ-037 Same-cycle lookup and update on 0x40 -> lookup shows old counter, next cycle shows new value.
REQ-038 Preload Br_Count to all-ones with CNT_W=4 (16 branches), one more branch -> Br_Count stays 4'hF; rst asserted mid-burst -> all counters and valid bits cleared immediately.
